// File: rtl/instruction_decoder_if.sv
// Fetch-to-decoder handshake: fetch side drives start/data_in, decoder drives ready.
interface instruction_decoder_if #(
  parameter int WIDTH_IN = 16
);
  logic                start;
  logic [WIDTH_IN-1:0] data_in;
  logic                ready;

  modport master (output start, output data_in, input ready);
  modport slave  (input start, input data_in, output ready);
endinterface

// File: rtl/instruction_decoder.sv
// Accumulator-based instruction decoder/executor at the consumer end of the fetch handshake.
// One word per handshake: opcode in the upper byte, operand in the lower byte.
module instruction_decoder #(
  parameter int BYTE_W      = 8,
  parameter int WIDTH_IN    = 2 * BYTE_W,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  instruction_decoder_if.slave    fetch,
  output logic                    busy,
  output logic [BYTE_W-1:0]       acc,
  output logic                    carry,
  output logic                    zero,
  output logic                    illegal,
  output logic                    halted,
  output logic [COUNT_WIDTH-1:0]  retired
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DECODE = 2'd1, ST_EXEC = 2'd2} state_e;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_LOAD = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_AND = 4'd4,
    OP_OR = 4'd5, OP_XOR = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8, OP_HALT = 4'd9,
    OP_ILL = 4'd10
  } op_e;

  function automatic op_e classify(input logic [7:0] opc);
    case (opc)
      8'h00:   classify = OP_NOP;
      8'h01:   classify = OP_LOAD;
      8'h02:   classify = OP_ADD;
      8'h03:   classify = OP_SUB;
      8'h04:   classify = OP_AND;
      8'h05:   classify = OP_OR;
      8'h06:   classify = OP_XOR;
      8'h07:   classify = OP_SHL;
      8'h08:   classify = OP_SHR;
      8'hFF:   classify = OP_HALT;
      default: classify = OP_ILL;
    endcase
  endfunction

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [WIDTH_IN-1:0]    instr_q, instr_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [BYTE_W-1:0]      acc_q, acc_d;
  logic                   carry_q, carry_d, zero_q, zero_d;
  logic                   illegal_q, illegal_d, halted_q, halted_d;
  logic                   ready_q, ready_d, busy_q, busy_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   done_s;

  logic [BYTE_W-1:0] operand_s, shl_s, shr_s;
  logic [BYTE_W:0]   sum_s, diff_s;

  assign operand_s = instr_q[BYTE_W-1:0];
  assign sum_s     = {1'b0, acc_q} + {1'b0, operand_s};
  // A negative 9-bit difference leaves the top bit set, which is exactly the borrow.
  assign diff_s    = {1'b0, acc_q} - {1'b0, operand_s};
  assign shl_s     = {acc_q[BYTE_W-2:0], 1'b0};
  assign shr_s     = {1'b0, acc_q[BYTE_W-1:1]};

  // Next-state and next-output computation for the IDLE/DECODE/EXEC sequence.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    halted_d  = halted_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    retired_d = retired_q;
    done_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch.start && ready_q) begin
          instr_d = fetch.data_in;
          state_d = ST_DECODE;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        op_d = classify(instr_q[WIDTH_IN-1:BYTE_W]);
        if ((op_d == OP_SHL) || (op_d == OP_SHR)) begin
          cnt_d = instr_q[2:0];
        end else begin
          cnt_d = 3'd0;
        end
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op_q)
          OP_NOP:  done_s = 1'b1;
          OP_LOAD: begin acc_d = operand_s; zero_d = (operand_s == '0); done_s = 1'b1; end
          OP_ADD:  begin {carry_d, acc_d} = sum_s; zero_d = (sum_s[BYTE_W-1:0] == '0); done_s = 1'b1; end
          OP_SUB:  begin {carry_d, acc_d} = diff_s; zero_d = (diff_s[BYTE_W-1:0] == '0); done_s = 1'b1; end
          OP_AND:  begin acc_d = acc_q & operand_s; zero_d = ((acc_q & operand_s) == '0); done_s = 1'b1; end
          OP_OR:   begin acc_d = acc_q | operand_s; zero_d = ((acc_q | operand_s) == '0); done_s = 1'b1; end
          OP_XOR:  begin acc_d = acc_q ^ operand_s; zero_d = ((acc_q ^ operand_s) == '0); done_s = 1'b1; end
          OP_SHL, OP_SHR: begin
            if (cnt_q != 3'd0) begin
              acc_d   = (op_q == OP_SHL) ? shl_s : shr_s;
              carry_d = (op_q == OP_SHL) ? acc_q[BYTE_W-1] : acc_q[0];
              cnt_d   = cnt_q - 3'd1;
              done_s  = (cnt_q == 3'd1);
              zero_d  = (cnt_q == 3'd1) ? (acc_d == '0) : zero_q;
            end else begin
              zero_d = (acc_q == '0);
              done_s = 1'b1;
            end
          end
          OP_HALT: begin halted_d = 1'b1; done_s = 1'b1; end
          OP_ILL:  done_s = 1'b1;
          default: done_s = 1'b1;
        endcase
        if (done_s) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          ready_d   = (op_q != OP_HALT) && !halted_q;
          illegal_d = (op_q == OP_ILL);
          retired_d = (op_q == OP_ILL) ? retired_q : retired_q + COUNT_WIDTH'(1);
        end else begin
          state_d = ST_EXEC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = !halted_q;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      instr_q   <= '0;
      cnt_q     <= 3'd0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      retired_q <= retired_d;
    end
  end

  assign fetch.ready = ready_q;
  assign busy        = busy_q;
  assign acc         = acc_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign illegal     = illegal_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed self-checking bench for instruction_decoder; expected values are hand-computed.
module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy, carry, zero, illegal, halted;
  logic [7:0] acc, retired;
  int         n_cmp = 0;
  int         n_err = 0;
  int         lat;

  instruction_decoder_if #(.WIDTH_IN(16)) dif ();

  instruction_decoder dut (
    .clk     (clk),
    .reset   (reset),
    .fetch   (dif),
    .busy    (busy),
    .acc     (acc),
    .carry   (carry),
    .zero    (zero),
    .illegal (illegal),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for one accept edge, then count edges until ready returns (bounded).
  task automatic run(input logic [15:0] word, output int edges);
    dif.start   = 1'b1;
    dif.data_in = word;
    tick();
    dif.start = 1'b0;
    edges = 1;
    while (!dif.ready && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ready"}, 32'(dif.ready), 32'h1);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_acc"}, 32'(acc), 32'h0);
    check_eq({tag, "_carry"}, 32'(carry), 32'h0);
    check_eq({tag, "_zero"}, 32'(zero), 32'h0);
    check_eq({tag, "_illegal"}, 32'(illegal), 32'h0);
    check_eq({tag, "_halted"}, 32'(halted), 32'h0);
    check_eq({tag, "_retired"}, 32'(retired), 32'h0);
  endtask

  initial begin
    bit saw_ready;
    reset       = 1'b1;
    dif.start   = 1'b0;
    dif.data_in = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("rst");

    run(16'h01F0, lat);
    check_eq("load_lat", 32'(lat), 32'd3);
    check_eq("load_acc", 32'(acc), 32'hF0);
    check_eq("load_zero", 32'(zero), 32'h0);
    check_eq("load_ret", 32'(retired), 32'h1);
    check_eq("load_busy", 32'(busy), 32'h0);

    run(16'h0220, lat);
    check_eq("add_acc", 32'(acc), 32'h10);
    check_eq("add_carry", 32'(carry), 32'h1);
    check_eq("add_zero", 32'(zero), 32'h0);

    run(16'h0311, lat);
    check_eq("sub_acc", 32'(acc), 32'hFF);
    check_eq("sub_borrow", 32'(carry), 32'h1);

    run(16'h0181, lat);
    run(16'h0703, lat);
    check_eq("shl3_lat", 32'(lat), 32'd5);
    check_eq("shl3_acc", 32'(acc), 32'h08);
    check_eq("shl3_carry", 32'(carry), 32'h0);
    check_eq("shl3_ret", 32'(retired), 32'h5);

    run(16'h02FF, lat);
    check_eq("add2_acc", 32'(acc), 32'h07);
    check_eq("add2_carry", 32'(carry), 32'h1);
    run(16'h0700, lat);
    check_eq("shl0_lat", 32'(lat), 32'd3);
    check_eq("shl0_acc", 32'(acc), 32'h07);
    check_eq("shl0_carry", 32'(carry), 32'h1);

    run(16'h0803, lat);
    check_eq("shr3_lat", 32'(lat), 32'd5);
    check_eq("shr3_acc", 32'(acc), 32'h00);
    check_eq("shr3_zero", 32'(zero), 32'h1);
    check_eq("shr3_ret", 32'(retired), 32'h8);

    run(16'h5512, lat);
    check_eq("ill_lat", 32'(lat), 32'd3);
    check_eq("ill_flag", 32'(illegal), 32'h1);
    check_eq("ill_acc", 32'(acc), 32'h00);
    check_eq("ill_zero", 32'(zero), 32'h1);
    check_eq("ill_ret", 32'(retired), 32'h8);

    run(16'h06FF, lat);
    check_eq("xor_acc", 32'(acc), 32'hFF);
    check_eq("xor_ill_clr", 32'(illegal), 32'h0);
    check_eq("xor_zero", 32'(zero), 32'h0);

    run(16'h040F, lat);
    check_eq("and_acc", 32'(acc), 32'h0F);
    run(16'h05F0, lat);
    check_eq("or_acc", 32'(acc), 32'hFF);
    run(16'h0000, lat);
    check_eq("nop_acc", 32'(acc), 32'hFF);
    check_eq("nop_carry", 32'(carry), 32'h1);
    check_eq("nop_ret", 32'(retired), 32'd12);

    // start held high across back-to-back words; words shown while busy must be ignored
    dif.start   = 1'b1;
    dif.data_in = 16'h0111;
    tick();
    dif.data_in = 16'h01AA;
    check_eq("b2b_ready0", 32'(dif.ready), 32'h0);
    check_eq("b2b_busy1", 32'(busy), 32'h1);
    tick();
    dif.data_in = 16'h01BB;
    tick();
    check_eq("b2b_acc1", 32'(acc), 32'h11);
    dif.data_in = 16'h0222;
    tick();
    check_eq("b2b_ready0b", 32'(dif.ready), 32'h0);
    dif.data_in = 16'h01CC;
    tick();
    tick();
    dif.start = 1'b0;
    check_eq("b2b_acc2", 32'(acc), 32'h33);
    check_eq("b2b_ret", 32'(retired), 32'd14);

    for (int i = 0; i < 242; i++) begin
      run(16'h0000, lat);
    end
    check_eq("ret_wrap", 32'(retired), 32'h0);

    dif.start   = 1'b1;
    dif.data_in = 16'hFF00;
    tick();
    dif.start = 1'b0;
    tick();
    tick();
    check_eq("halt_flag", 32'(halted), 32'h1);
    check_eq("halt_busy", 32'(busy), 32'h0);
    check_eq("halt_ret", 32'(retired), 32'h1);
    saw_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dif.start   = (i % 2 == 0);
      dif.data_in = 16'h0177;
      if (dif.ready) saw_ready = 1'b1;
      tick();
    end
    dif.start = 1'b0;
    check_eq("halt_no_ready", 32'(saw_ready), 32'h0);
    check_eq("halt_acc", 32'(acc), 32'h33);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst2");

    run(16'h015A, lat);
    dif.start   = 1'b1;
    dif.data_in = 16'h0707;
    tick();
    dif.start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_mid");
    run(16'h0142, lat);
    check_eq("post_rst_lat", 32'(lat), 32'd3);
    check_eq("post_rst_acc", 32'(acc), 32'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
